fa_2ha_311: RTL and testbench
=============================

FA_2HA_311 -- requirements
Module: fa_2ha_311

Parameters
REQ-001 The block SHALL have parameter CNT_W, default 8, which sets the width of op_count.

Interface
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single clock; every register uses its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide, and is the reset; reset is asynchronous and active-low.
REQ-004 Ports a and b SHALL be inputs, 1 bit wide each, and are the addend bits.
REQ-005 Port c SHALL be an input, 1 bit wide, and is the carry-in bit.
REQ-006 Port in_valid SHALL be an input, 1 bit wide; when high, a, b and c are captured at the clk edge.
REQ-007 Port s_311 SHALL be an output, 1 bit wide, and is the combinational sum.
REQ-008 Port cy_311 SHALL be an output, 1 bit wide, and is the combinational carry-out.
REQ-009 Ports ha1_s, ha1_c and ha2_c SHALL be outputs, 1 bit wide each, and are combinational debug taps of the half-adder internals.
REQ-010 Ports s_q and cy_q SHALL be outputs, 1 bit wide each, and are the registered sum and carry.
REQ-011 Port out_valid SHALL be an output, 1 bit wide, and qualifies s_q and cy_q.
REQ-012 Port op_count SHALL be an output, CNT_W bits wide, and counts accepted operations.

Function
REQ-013 The combinational path SHALL be built as two half adders:
- HA1 takes (a, b) and produces ha1_s = a^b and ha1_c = a&b.
- HA2 takes (ha1_s, c) and produces s_311 = ha1_s^c and ha2_c = ha1_s&c.
REQ-014 cy_311 SHALL equal ha1_c | ha2_c, so that {cy_311, s_311} = a + b + c for every input combination.
REQ-015 ha1_c and ha2_c SHALL never be high at the same time; the OR of the two carries is therefore exact.
REQ-016 s_311, cy_311 and the debug taps SHALL be purely combinational, with no clock dependency.
REQ-017 On a clk rising edge with in_valid = 1:
- s_q and cy_q take the current s_311 and cy_311.
- out_valid is set to 1.
REQ-018 On a clk rising edge with in_valid = 0:
- s_q and cy_q hold their values.
- out_valid is set to 0.
REQ-019 Registered latency SHALL be exactly 1 cycle from input capture to s_q, cy_q and out_valid.
REQ-020 op_count SHALL increment by 1 on each rising edge where in_valid = 1, and SHALL saturate at 2^CNT_W-1 (no wrap-around).
REQ-021 Input changes between clk edges SHALL affect only the combinational outputs, never the registered outputs.

Reset
REQ-022 While rst_n = 0, the following SHALL be 0 immediately, independent of clk:
- s_q, cy_q and out_valid;
- op_count.
REQ-023 The combinational outputs SHALL keep tracking a, b and c during reset.
REQ-024 A reset asserted mid-operation SHALL discard any capture in flight; out_valid is 0 on the first edge after rst_n is released unless in_valid is high at that edge.
REQ-025 Release of rst_n SHALL take effect so that the first capture occurs on the first rising clk edge where rst_n = 1.

Verification
REQ-026 Exhaustive truth table: with rst_n = 1, step {a,b,c} through 000..111 at 50 ns each. The required {cy_311, s_311} sequence is 00, 01, 01, 10, 01, 10, 10, 11.
REQ-027 Half-adder taps:
- a=1, b=1, c=0 -> ha1_s=0, ha1_c=1, ha2_c=0.
- a=1, b=0, c=1 -> ha1_s=1, ha1_c=0, ha2_c=1.
REQ-028 Registered latency: drive a=1, b=1, c=1 with in_valid=1 for one edge. One cycle later s_q=1, cy_q=1 and out_valid=1; on the next edge with in_valid=0, out_valid=0 and s_q, cy_q hold.
REQ-029 Asynchronous reset: with s_q=1 and op_count=5, drive rst_n low between edges. s_q, cy_q, out_valid and op_count go to 0 without a clk edge, while s_311 still follows the inputs.
REQ-030 Counter saturation: with CNT_W=2, hold in_valid=1 for 6 edges. op_count reads 1, 2, 3, 3, 3, 3.

Source files
------------

// File: rtl/fa_2ha_311.sv
// Full adder built from two half adders, with a registered copy of the result
// and a saturating count of accepted operations.
module fa_2ha_311 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             in_valid,
    output logic             s_311,
    output logic             cy_311,
    output logic             ha1_s,
    output logic             ha1_c,
    output logic             ha2_c,
    output logic             s_q,
    output logic             cy_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] op_count
);

    logic             w_ha1_s;
    logic             w_ha1_c;
    logic             w_ha2_s;
    logic             w_ha2_c;
    logic             w_cy;
    logic             r_s_q;
    logic             r_cy_q;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_op_count;

    assign w_ha1_s = a ^ b;
    assign w_ha1_c = a & b;
    assign w_ha2_s = w_ha1_s ^ c;
    assign w_ha2_c = w_ha1_s & c;
    // The two half-adder carries are mutually exclusive, so OR gives the exact carry.
    assign w_cy    = w_ha1_c | w_ha2_c;

    assign s_311     = w_ha2_s;
    assign cy_311    = w_cy;
    assign ha1_s     = w_ha1_s;
    assign ha1_c     = w_ha1_c;
    assign ha2_c     = w_ha2_c;
    assign s_q       = r_s_q;
    assign cy_q      = r_cy_q;
    assign out_valid = r_out_valid;
    assign op_count  = r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q       <= 1'b0;
            r_cy_q      <= 1'b0;
            r_out_valid <= 1'b0;
            r_op_count  <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_s_q  <= w_ha2_s;
                r_cy_q <= w_cy;
                // Counter sticks at all-ones instead of wrapping.
                if (r_op_count != {CNT_W{1'b1}}) begin
                    r_op_count <= r_op_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fa_2ha_311.sv
// Directed bench for fa_2ha_311: truth table, taps, latency, async reset
// and counter saturation on a narrow second instance.
module tb_fa_2ha_311;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a, b, c;
    logic       in_valid;
    logic       vs;

    logic       s_311, cy_311, ha1_s, ha1_c, ha2_c, s_q, cy_q, out_valid;
    logic [7:0] op_count;
    logic       s2_311, cy2_311, ha1_s2, ha1_c2, ha2_c2, s2_q, cy2_q, out_valid2;
    logic [1:0] op_count2;

    int total = 0;
    int bad   = 0;

    logic [1:0] expTab [8];
    logic [1:0] expSat [6];

    fa_2ha_311 #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .in_valid(in_valid),
        .s_311(s_311), .cy_311(cy_311), .ha1_s(ha1_s), .ha1_c(ha1_c), .ha2_c(ha2_c),
        .s_q(s_q), .cy_q(cy_q), .out_valid(out_valid), .op_count(op_count)
    );

    fa_2ha_311 #(.CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .in_valid(vs),
        .s_311(s2_311), .cy_311(cy2_311), .ha1_s(ha1_s2), .ha1_c(ha1_c2), .ha2_c(ha2_c2),
        .s_q(s2_q), .cy_q(cy2_q), .out_valid(out_valid2), .op_count(op_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        expTab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        expSat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; in_valid = 1'b0; vs = 1'b0;
        #2;
        check("rst_s_q", 32'(s_q), 32'd0);
        check("rst_cy_q", 32'(cy_q), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        a = 1'b1;
        #1;
        check("rst_comb_s", 32'(s_311), 32'd1);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {a, b, c} = 3'(i);
            #1;
            check($sformatf("tt_%0d", i), 32'({cy_311, s_311}), 32'(expTab[i]));
            #49;
        end
        check("tt_no_capture", 32'(op_count), 32'd0);

        {a, b, c} = 3'b110;
        #1;
        check("tap110_ha1_s", 32'(ha1_s), 32'd0);
        check("tap110_ha1_c", 32'(ha1_c), 32'd1);
        check("tap110_ha2_c", 32'(ha2_c), 32'd0);
        {a, b, c} = 3'b101;
        #1;
        check("tap101_ha1_s", 32'(ha1_s), 32'd1);
        check("tap101_ha1_c", 32'(ha1_c), 32'd0);
        check("tap101_ha2_c", 32'(ha2_c), 32'd1);

        @(negedge clk);
        {a, b, c} = 3'b111; in_valid = 1'b1;
        @(negedge clk);
        check("lat_s_q", 32'(s_q), 32'd1);
        check("lat_cy_q", 32'(cy_q), 32'd1);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_op_count", 32'(op_count), 32'd1);
        in_valid = 1'b0; {a, b, c} = 3'b000;
        @(negedge clk);
        check("hold_out_valid", 32'(out_valid), 32'd0);
        check("hold_s_q", 32'(s_q), 32'd1);
        check("hold_cy_q", 32'(cy_q), 32'd1);

        {a, b, c} = 3'b100; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_rst_count", 32'(op_count), 32'd5);
        check("pre_rst_s_q", 32'(s_q), 32'd1);
        check("pre_rst_cy_q", 32'(cy_q), 32'd0);
        in_valid = 1'b0;
        {a, b, c} = 3'b011;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_s_q", 32'(s_q), 32'd0);
        check("arst_cy_q", 32'(cy_q), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_op_count", 32'(op_count), 32'd0);
        check("arst_comb", 32'({cy_311, s_311}), 32'd2);
        b = 1'b0;
        #1;
        check("arst_comb_track", 32'({cy_311, s_311}), 32'd1);

        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_count", 32'(op_count), 32'd0);
        in_valid = 1'b1; {a, b, c} = 3'b001;
        @(negedge clk);
        check("first_cap_valid", 32'(out_valid), 32'd1);
        check("first_cap_s_q", 32'(s_q), 32'd1);
        check("first_cap_count", 32'(op_count), 32'd1);
        in_valid = 1'b0;

        check("sat_start", 32'(op_count2), 32'd0);
        vs = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("sat_%0d", i), 32'(op_count2), 32'(expSat[i]));
        end
        vs = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
